mem_arbiter: RTL and testbench

Shares the single Avalon-MM master port of the Dijkstra accelerator between NUM_REQ requesters: the graph reader, the Writer that stores prev_vector, and any debug or readback agent. Arbitration is round-robin with an optional lock for multi-beat sequences, and only one transaction is outstanding at a time. The block sits between the requester masters and the external memory interconnect.

---
 rtl/dijkstra_pkg.sv | 18 +
 rtl/rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dijkstra_pkg.sv
// Shared types and width defaults for the Dijkstra accelerator memory path.
package dijkstra_pkg;

  localparam int DEFAULT_MADDR_WIDTH = 32;
  localparam int DEFAULT_MDATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_READ
  } ArbState;

  // A single requester still needs a one-bit pointer to keep port widths legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_picker
  import dijkstra_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between NUM_REQ requesters,
// with optional lock for back-to-back sequences and one transaction outstanding.
module mem_arbiter
  import dijkstra_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_read,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MDATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_wait_request,
  output logic [MDATA_WIDTH-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]             req_readdatavalid,
  output logic [NUM_REQ-1:0]             grant,
  output logic [MADDR_WIDTH-1:0]         avm_address,
  output logic                           avm_read,
  output logic                           avm_write,
  output logic [MDATA_WIDTH-1:0]         avm_writedata,
  input  logic                           avm_waitrequest,
  input  logic [MDATA_WIDTH-1:0]         avm_readdata,
  input  logic                           avm_readdatavalid
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  ArbState            state, state_n;
  logic [PTR_W-1:0]   ptr, grant_idx, win_idx, load_idx;
  logic [NUM_REQ-1:0] candidates, winner, load_onehot;
  logic               pick_valid, accept, complete, load;

  assign candidates = req_read | req_write;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req   (candidates),
    .ptr   (ptr),
    .winner(winner),
    .valid (pick_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
  end

  assign accept   = (state == ISSUE) && !avm_waitrequest;
  assign complete = (accept && avm_write) || ((state == WAIT_READ) && avm_readdatavalid);

  // A completing locked owner that is still requesting reloads without passing through IDLE.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_idx = grant_idx;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          load     = 1'b1;
          load_idx = win_idx;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (accept && !avm_write) state_n = WAIT_READ;
      end
      WAIT_READ: ;
      default: state_n = IDLE;
    endcase
    if (complete) begin
      if (req_lock[grant_idx] && candidates[grant_idx]) begin
        load     = 1'b1;
        load_idx = grant_idx;
        state_n  = ISSUE;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_comb begin
    load_onehot           = '0;
    load_onehot[load_idx] = 1'b1;
  end

  always_comb begin
    req_wait_request  = '1;
    req_readdatavalid = '0;
    if (state == ISSUE)     req_wait_request[grant_idx]  = avm_waitrequest;
    if (state == WAIT_READ) req_readdatavalid[grant_idx] = avm_readdatavalid;
  end

  assign req_readdata = avm_readdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_idx     <= '0;
      grant         <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
    end else begin
      state <= state_n;
      if (complete) begin
        ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      // Write wins when a requester raises read and write together.
      if (load) begin
        grant         <= load_onehot;
        grant_idx     <= load_idx;
        avm_address   <= req_addr[int'(load_idx)*MADDR_WIDTH +: MADDR_WIDTH];
        avm_writedata <= req_wdata[int'(load_idx)*MDATA_WIDTH +: MDATA_WIDTH];
        avm_write     <= req_write[load_idx];
        avm_read      <= req_read[load_idx] & ~req_write[load_idx];
      end else begin
        if (accept) begin
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
        end
        if (complete) grant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboarded multi-cycle sequences.
module tb_mem_arbiter;
  import dijkstra_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_read, req_write, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_wait_request, req_readdatavalid, grant;
  logic [DW-1:0]   req_readdata;
  logic [AW-1:0]   avm_address;
  logic            avm_read, avm_write;
  logic [DW-1:0]   avm_writedata;
  logic            avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0]   avm_readdata;

  typedef struct {
    logic          rd;
    logic          wr;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
  } rexp_t;

  typedef struct {
    int            idx;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    int            rdlat;
    logic          exp_wr;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  cmd_t  q0[$];
  cmd_t  q1[$];
  exp_t  sb[$];
  rexp_t rsb[$];

  int   checks = 0;
  int   failures = 0;
  int   wait_cycles = 0;
  int   rd_lat = 1;
  logic spurious = 1'b0;

  mem_arbiter #(
    .NUM_REQ    (N),
    .MADDR_WIDTH(AW),
    .MDATA_WIDTH(DW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_lock         (req_lock),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_wait_request (req_wait_request),
    .req_readdata     (req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .grant            (grant),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic drive_reqs();
    req_read  = '0;
    req_write = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    if (q0.size() > 0) begin
      req_read[0] = q0[0].rd;
      req_write[0] = q0[0].wr;
      req_lock[0] = q0[0].lock;
      req_addr[0*AW +: AW] = q0[0].addr;
      req_wdata[0*DW +: DW] = q0[0].wdata;
    end
    if (q1.size() > 0) begin
      req_read[1] = q1[0].rd;
      req_write[1] = q1[0].wr;
      req_lock[1] = q1[0].lock;
      req_addr[1*AW +: AW] = q1[0].addr;
      req_wdata[1*DW +: DW] = q1[0].wdata;
    end
  endtask

  task automatic push_cmd(input int idx, input logic rd, input logic wr, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.lock = lock; c.addr = addr; c.wdata = wdata;
    if (idx == 0) q0.push_back(c);
    else q1.push_back(c);
  endtask

  task automatic push_exp(input int idx, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    exp_t e;
    e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input vec_t v);
    wait_cycles = v.waits;
    rd_lat      = v.rdlat;
    push_cmd(v.idx, v.rd, v.wr, 1'b0, v.addr, v.wdata);
    push_exp(v.idx, v.exp_wr, v.addr, v.wdata, v.exp_rdata);
    drive_reqs();
  endtask

  task automatic check_reset_values(input string name);
    logic [N-1:0] ones;
    ones = '1;
    check_output({name, "_grant"}, grant, 0);
    check_output({name, "_avm_read"}, avm_read, 0);
    check_output({name, "_avm_write"}, avm_write, 0);
    check_output({name, "_avm_address"}, avm_address, 0);
    check_output({name, "_avm_writedata"}, avm_writedata, 0);
    check_output({name, "_wait_request"}, req_wait_request, ones);
    check_output({name, "_readdatavalid"}, req_readdatavalid, 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || rsb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("[TB] FAIL %s_timeout actual_pending=%0d required=0", name, sb.size() + rsb.size());
    end
    repeat (2) @(posedge clock);
    #2;
    check_output({name, "_grant_idle"}, grant, 0);
    check_output({name, "_read_idle"}, avm_read, 0);
    check_output({name, "_write_idle"}, avm_write, 0);
    sb.delete(); rsb.delete(); q0.delete(); q1.delete();
    drive_reqs();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    q0.delete(); q1.delete(); sb.delete(); rsb.delete();
    drive_reqs();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  // Slave model and scoreboard monitor: decides waitrequest mid-cycle, checks accepted commands.
  initial begin : bus
    int            wcnt, rd_cnt, cmd_cycles, acc_idx;
    logic          accept;
    logic [DW-1:0] rd_val;
    logic [N-1:0]  exp_wait, ones;
    exp_t          e;
    rexp_t         r;
    wcnt = 0; rd_cnt = 0; cmd_cycles = 0; rd_val = '0; ones = '1;
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rd_val;
        end
      end
      if (spurious) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hBAD0_BAD0;
        spurious          = 1'b0;
      end
      accept  = 1'b0;
      acc_idx = -1;
      if (avm_read || avm_write) begin
        cmd_cycles++;
        if (wcnt < wait_cycles) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          avm_waitrequest = 1'b0;
          accept = 1'b1;
          wcnt = 0;
        end
      end else begin
        avm_waitrequest = 1'b1;
        wcnt = 0;
        cmd_cycles = 0;
      end
      #1;
      if (accept) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_txn actual_addr=0x%0h required=none", avm_address);
        end else begin
          e = sb.pop_front();
          acc_idx = e.idx;
          check_output("txn_grant", grant, onehot(e.idx));
          check_output("txn_write", avm_write, e.wr);
          check_output("txn_read", avm_read, !e.wr);
          check_output("txn_addr", avm_address, e.addr);
          if (e.wr) begin
            check_output("txn_wdata", avm_writedata, e.wdata);
          end else begin
            rd_cnt  = rd_lat;
            rd_val  = avm_address;
            r.idx   = e.idx;
            r.rdata = e.rdata;
            rsb.push_back(r);
          end
          check_output("cmd_cycles", cmd_cycles, wait_cycles + 1);
          exp_wait = ~onehot(e.idx);
          check_output("accept_wait_request", req_wait_request, exp_wait);
        end
        cmd_cycles = 0;
      end else if (!reset) begin
        check_output("held_wait_request", req_wait_request, ones);
      end
      if (avm_readdatavalid) begin
        if (rsb.size() > 0) begin
          r = rsb.pop_front();
          check_output("rdv_onehot", req_readdatavalid, onehot(r.idx));
          check_output("rdata", req_readdata, r.rdata);
        end else begin
          check_output("spurious_rdv", req_readdatavalid, 0);
        end
      end else begin
        check_output("rdv_quiet", req_readdatavalid, 0);
      end
      @(posedge clock);
      #1;
      if (acc_idx == 0 && q0.size() > 0) void'(q0.pop_front());
      if (acc_idx == 1 && q1.size() > 0) void'(q1.pop_front());
      drive_reqs();
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    vec_t vecs[5];
    int   n;
    vecs[0] = '{1, 1'b0, 1'b1, 32'h40, 32'hDEAD,     2, 1, 1'b1, 32'h0};
    vecs[1] = '{0, 1'b1, 1'b0, 32'h11, 32'h0,        0, 1, 1'b0, 32'h11};
    vecs[2] = '{1, 1'b1, 1'b0, 32'h80, 32'h0,        1, 3, 1'b0, 32'h80};
    vecs[3] = '{0, 1'b1, 1'b1, 32'h24, 32'h5A5A,     0, 1, 1'b1, 32'h0};
    vecs[4] = '{0, 1'b0, 1'b1, 32'h3C, 32'hFFFFFFFF, 3, 1, 1'b1, 32'h0};

    drive_reqs();
    repeat (3) @(posedge clock);
    #2;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clock);
    #2;

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i]);
      wait_done($sformatf("vec%0d", i));
    end

    // Both requesters read together: requester 0 first after reset, then 1.
    do_reset();
    wait_cycles = 0; rd_lat = 2;
    push_cmd(0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0);
    push_cmd(1, 1'b1, 1'b0, 1'b0, 32'h22, 32'h0);
    push_exp(0, 1'b0, 32'h11, 32'h0, 32'h11);
    push_exp(1, 1'b0, 32'h22, 32'h0, 32'h22);
    drive_reqs();
    wait_done("concurrent");

    // Unlocked continuous writers must alternate.
    do_reset();
    wait_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      push_cmd(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hA0 + k);
      push_cmd(1, 1'b0, 1'b1, 1'b0, 32'h104, 32'hB0 + k);
      push_exp(0, 1'b1, 32'h100, 32'hA0 + k, 32'h0);
      push_exp(1, 1'b1, 32'h104, 32'hB0 + k, 32'h0);
    end
    drive_reqs();
    wait_done("fairness");

    // Requester 0 holds lock across four writes while requester 1 waits.
    do_reset();
    wait_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      push_cmd(0, 1'b0, 1'b1, (k < 3), 32'h200, 32'hC0DE);
      push_exp(0, 1'b1, 32'h200, 32'hC0DE, 32'h0);
    end
    push_cmd(1, 1'b0, 1'b1, 1'b0, 32'h300, 32'hF00D);
    push_exp(1, 1'b1, 32'h300, 32'hF00D, 32'h0);
    drive_reqs();
    wait_done("lock");

    // Reset while waiting for read data; the late and spurious data must not surface.
    do_reset();
    wait_cycles = 0; rd_lat = 6;
    push_cmd(0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0);
    push_exp(0, 1'b0, 32'h55, 32'h0, 32'h55);
    drive_reqs();
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #2;
    check_output("midread_reached", (n < 50), 1);
    check_output("midread_grant", grant, onehot(0));
    check_output("midread_read_dropped", avm_read, 0);
    reset = 1'b1;
    q0.delete(); q1.delete(); rsb.delete();
    drive_reqs();
    @(posedge clock);
    #2;
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    spurious = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check_output("post_spurious_grant", grant, 0);
    check_output("post_spurious_read", avm_read, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
